alu_seq: RTL and testbench

Parametrised, registered successor to the 4-bit combinational ALU; same opcode set and Sel encoding, generalised to W-bit operands with a 2W-bit result.
- Adds valid/ready handshakes on input and output.
- Multiply is an iterative shift-add over W cycles.
- Sits between operand registers and the writeback/display path of the datapath.

---
 rtl/alu_seq_pkg.sv | 26 ++
 rtl/alu_seq_mul.sv | 51 +++++
 rtl/alu_seq.sv | 145 ++++++++++++++
 tb/tb_alu_seq.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared opcodes, FSM state type and flag bit positions for the sequential ALU.
package alu_seq_pkg;

   localparam logic [3:0] OP_SUM = 4'b0000;
   localparam logic [3:0] OP_SUB = 4'b1111;
   localparam logic [3:0] OP_AND = 4'b0001;
   localparam logic [3:0] OP_OR  = 4'b0010;
   localparam logic [3:0] OP_XOR = 4'b0100;
   localparam logic [3:0] OP_EQ  = 4'b1000;
   localparam logic [3:0] OP_GT  = 4'b0011;
   localparam logic [3:0] OP_SHL = 4'b0110;
   localparam logic [3:0] OP_SHR = 4'b1100;
   localparam logic [3:0] OP_MUL = 4'b0101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int unsigned FLAG_Z  = 3;
   localparam int unsigned FLAG_N  = 2;
   localparam int unsigned FLAG_CY = 1;
   localparam int unsigned FLAG_V  = 0;

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative shift-add unsigned multiplier: one partial product per cycle, LSB first.
// done_c/product_c are combinational so the last partial product lands directly in the consumer's register.
module alu_seq_mul #(
   parameter int unsigned W = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   output logic           done_c,
   output logic [2*W-1:0] product_c
);

   localparam int unsigned CW = 2 * W;
   localparam int unsigned NW = $clog2(W) + 1;

   logic [CW-1:0] mcand;
   logic [W-1:0]  mplier;
   logic [CW-1:0] acc;
   logic [NW-1:0] cnt;
   logic          run;

   assign product_c = acc + (mplier[0] ? mcand : '0);
   assign done_c    = run && (cnt == NW'(W - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
         cnt    <= '0;
         run    <= 1'b0;
      end else if (start) begin
         mcand  <= CW'(a);
         mplier <= b;
         acc    <= '0;
         cnt    <= '0;
         run    <= 1'b1;
      end else if (run) begin
         acc    <= product_c;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         cnt    <= cnt + NW'(1);
         if (done_c) begin
            run <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/alu_seq.sv
// Registered W-bit ALU with valid/ready handshakes and a W-cycle multiply.
// Optional build macro ALU_SEQ_FLAGS_EN adds the Flags output {Z, N, Cy, V}.
module alu_seq
   import alu_seq_pkg::*;
#(
   parameter int unsigned W   = 4,
   parameter int unsigned SHW = $clog2(2 * W)
) (
   input  logic           Clk,
   input  logic           Rst,
   input  logic           In_Valid,
   output logic           In_Ready,
   input  logic [W-1:0]   A,
   input  logic [W-1:0]   B,
   input  logic [3:0]     Sel,
   output logic           Out_Valid,
   input  logic           Out_Ready,
   output logic [2*W-1:0] C,
   output logic           Busy
`ifdef ALU_SEQ_FLAGS_EN
   ,
   output logic [3:0]     Flags
`endif
);

   localparam int unsigned CW = 2 * W;

   state_t        state;
   state_t        state_nxt;
   logic [CW-1:0] c_nxt;
   logic [CW-1:0] alu_c;
   logic [CW-1:0] sum_c;
   logic [W:0]    diff_c;
   logic          accept_c;
   logic          mul_start_c;
   logic          mul_done_c;
   logic [CW-1:0] mul_product_c;

   // In DONE a new op may enter only while the current result is being taken.
   assign In_Ready = (state == IDLE) || ((state == DONE) && Out_Ready);
   assign accept_c = In_Valid && In_Ready;

   assign sum_c  = CW'(A) + CW'(B);
   assign diff_c = {1'b0, A} - {1'b0, B};

   // Single-cycle operations, evaluated on the operands presented at accept.
   always_comb begin
      alu_c = '0;
      case (Sel)
         OP_SUM: alu_c = sum_c;
         OP_SUB: alu_c = {{(W - 1){diff_c[W]}}, diff_c};
         OP_AND: alu_c = CW'(A & B);
         OP_OR:  alu_c = CW'(A | B);
         OP_XOR: alu_c = CW'(A ^ B);
         OP_EQ:  alu_c = CW'(A == B);
         OP_GT:  alu_c = CW'(A > B);
         OP_SHL: alu_c = (32'(B) >= 32'(CW)) ? '0 : (CW'(A) << B[SHW-1:0]);
         OP_SHR: alu_c = (32'(B) >= 32'(W)) ? '0 : CW'(A >> B);
         default: alu_c = '0;
      endcase
   end

   alu_seq_mul #(.W(W)) u_mul (
      .clk       (Clk),
      .rst       (Rst),
      .start     (mul_start_c),
      .a         (A),
      .b         (B),
      .done_c    (mul_done_c),
      .product_c (mul_product_c)
   );

   always_comb begin
      state_nxt   = state;
      c_nxt       = C;
      mul_start_c = 1'b0;
      case (state)
         IDLE, DONE: begin
            if (accept_c) begin
               if (Sel == OP_MUL) begin
                  state_nxt   = MUL;
                  mul_start_c = 1'b1;
               end else begin
                  state_nxt = DONE;
                  c_nxt     = alu_c;
               end
            end else if ((state == DONE) && Out_Ready) begin
               state_nxt = IDLE;
            end
         end
         MUL: begin
            if (mul_done_c) begin
               state_nxt = DONE;
               c_nxt     = mul_product_c;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state     <= IDLE;
         C         <= '0;
         Out_Valid <= 1'b0;
         Busy      <= 1'b0;
      end else begin
         state     <= state_nxt;
         C         <= c_nxt;
         Out_Valid <= (state_nxt == DONE);
         Busy      <= (state_nxt == MUL);
      end
   end

`ifdef ALU_SEQ_FLAGS_EN
   logic       load_alu_c;
   logic       load_mul_c;
   logic [3:0] flags_nxt;

   assign load_alu_c = accept_c && (Sel != OP_MUL);
   assign load_mul_c = (state == MUL) && mul_done_c;

   // Carry and overflow only mean something for the add/subtract results.
   always_comb begin
      flags_nxt = Flags;
      if (load_alu_c || load_mul_c) begin
         flags_nxt[FLAG_Z]  = (c_nxt == '0);
         flags_nxt[FLAG_N]  = c_nxt[CW-1];
         flags_nxt[FLAG_CY] = load_alu_c && (Sel == OP_SUM) && sum_c[W];
         flags_nxt[FLAG_V]  = load_alu_c &&
            (((Sel == OP_SUM) && (A[W-1] == B[W-1]) && (sum_c[W-1] != A[W-1])) ||
             ((Sel == OP_SUB) && (A[W-1] != B[W-1]) && (diff_c[W-1] != A[W-1])));
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         Flags <= '0;
      end else begin
         Flags <= flags_nxt;
      end
   end
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (W=4): directed corner cases plus randomized traffic.
module tb_alu_seq;

   logic       Clk = 1'b0;
   logic       Rst = 1'b1;
   logic       In_Valid = 1'b0;
   logic       In_Ready;
   logic [3:0] A = '0;
   logic [3:0] B = '0;
   logic [3:0] Sel = '0;
   logic       Out_Valid;
   logic       Out_Ready = 1'b0;
   logic [7:0] C;
   logic       Busy;
`ifdef ALU_SEQ_FLAGS_EN
   logic [3:0] Flags;
`endif

   typedef struct {
      logic [7:0] c;
      logic [3:0] f;
   } exp_t;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   bit   rnd_ready = 1'b0;
   bit   hold = 1'b0;
   logic [7:0] hold_c = '0;

   alu_seq #(.W(4)) dut (
      .Clk       (Clk),
      .Rst       (Rst),
      .In_Valid  (In_Valid),
      .In_Ready  (In_Ready),
      .A         (A),
      .B         (B),
      .Sel       (Sel),
      .Out_Valid (Out_Valid),
      .Out_Ready (Out_Ready),
      .C         (C),
      .Busy      (Busy)
`ifdef ALU_SEQ_FLAGS_EN
      ,
      .Flags     (Flags)
`endif
   );

   always #5 Clk = ~Clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference behaviour from the opcode definitions, using plain integer arithmetic.
   function automatic exp_t model(input logic [3:0] s, input logic [3:0] a, input logic [3:0] b);
      int   ia = int'(a);
      int   ib = int'(b);
      int   sa = (ia >= 8) ? ia - 16 : ia;
      int   sb = (ib >= 8) ? ib - 16 : ib;
      int   r  = 0;
      exp_t e;
      e.f = '0;
      case (s)
         4'b0000: begin
            r = ia + ib;
            e.f[1] = (r > 15);
            e.f[0] = ((sa + sb) > 7) || ((sa + sb) < -8);
         end
         4'b1111: begin
            r = ia - ib;
            e.f[0] = ((sa - sb) > 7) || ((sa - sb) < -8);
         end
         4'b0001: r = ia & ib;
         4'b0010: r = ia | ib;
         4'b0100: r = ia ^ ib;
         4'b1000: r = (ia == ib) ? 1 : 0;
         4'b0011: r = (ia > ib) ? 1 : 0;
         4'b0110: r = (ib >= 8) ? 0 : (ia << ib);
         4'b1100: r = (ib >= 4) ? 0 : (ia >> ib);
         4'b0101: r = ia * ib;
         default: r = 0;
      endcase
      e.c = 8'(r);
      e.f[3] = (e.c == 8'h00);
      e.f[2] = e.c[7];
      return e;
   endfunction

   // Present one op and hold it until accepted; returns on the negedge after the accept edge.
   task automatic issue(input logic [3:0] s, input logic [3:0] a, input logic [3:0] b);
      bit done = 1'b0;
      In_Valid = 1'b1;
      Sel = s;
      A = a;
      B = b;
      for (int k = 0; k < 100 && !done; k++) begin
         #2;
         if (In_Ready) begin
            exp_q.push_back(model(s, a, b));
            done = 1'b1;
         end
         @(negedge Clk);
      end
      In_Valid = 1'b0;
      A = 4'($urandom);
      B = 4'($urandom);
      Sel = 4'($urandom);
      check("issue_accepted", 32'(done), 32'd1);
   endtask

   always @(negedge Clk) begin
      if (rnd_ready) begin
         Out_Ready = ($urandom_range(0, 3) != 0);
      end
   end

   // Monitor: compares every delivered result against the scoreboard, and checks held results stay put.
   always @(negedge Clk) begin
      exp_t e;
      #3;
      if (Rst) begin
         hold = 1'b0;
      end else begin
         if (hold) begin
            check("hold_valid", 32'(Out_Valid), 32'd1);
            check("hold_c", 32'(C), 32'(hold_c));
         end
         hold = 1'b0;
         if (Out_Valid) begin
            if (Out_Ready) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_output", 32'(C), 32'hFFFF_FFFF);
               end else begin
                  e = exp_q.pop_front();
                  check("result_c", 32'(C), 32'(e.c));
`ifdef ALU_SEQ_FLAGS_EN
                  check("result_flags", 32'(Flags), 32'(e.f));
`endif
               end
            end else begin
               hold   = 1'b1;
               hold_c = C;
            end
         end
      end
   end

   initial begin
      Rst = 1'b1;
      repeat (2) @(negedge Clk);
      Rst = 1'b0;
      #2;
      check("reset_in_ready", 32'(In_Ready), 32'd1);
      check("reset_out_valid", 32'(Out_Valid), 32'd0);
      check("reset_c", 32'(C), 32'd0);
      check("reset_busy", 32'(Busy), 32'd0);
      @(negedge Clk);

      // SUM then back-to-back SUB accepted in the DONE cycle
      Out_Ready = 1'b1;
      issue(4'b0000, 4'b0010, 4'b1000);
      #1 check("sum_latency_valid", 32'(Out_Valid), 32'd1);
      issue(4'b1111, 4'b0010, 4'b1000);
      #1 check("sub_b2b_valid", 32'(Out_Valid), 32'd1);

      // MUL: busy for W cycles with operand noise ignored
      issue(4'b0101, 4'b1011, 4'b0111);
      for (int k = 0; k < 4; k++) begin
         #2;
         check("mul_busy", 32'(Busy), 32'd1);
         check("mul_in_ready", 32'(In_Ready), 32'd0);
         check("mul_out_valid", 32'(Out_Valid), 32'd0);
         In_Valid = 1'b1;
         A = 4'($urandom);
         B = 4'($urandom);
         Sel = 4'b0000;
         @(negedge Clk);
      end
      In_Valid = 1'b0;
      #2;
      check("mul_done_valid", 32'(Out_Valid), 32'd1);
      check("mul_done_busy", 32'(Busy), 32'd0);
      @(negedge Clk);

      // Backpressure: result held, new requests refused
      Out_Ready = 1'b0;
      issue(4'b0000, 4'd3, 4'd4);
      for (int k = 0; k < 5; k++) begin
         #2;
         check("bp_valid", 32'(Out_Valid), 32'd1);
         check("bp_c", 32'(C), 32'h07);
         check("bp_in_ready", 32'(In_Ready), 32'd0);
         In_Valid = 1'b1;
         Sel = 4'b1111;
         A = 4'($urandom);
         B = 4'($urandom);
         @(negedge Clk);
      end
      In_Valid = 1'b0;
      Out_Ready = 1'b1;
      @(negedge Clk);

      // Reset two cycles into a multiply discards it
      issue(4'b0101, 4'hF, 4'hF);
      @(negedge Clk);
      Rst = 1'b1;
      exp_q.delete();
      @(negedge Clk);
      #1;
      check("rst_mul_valid", 32'(Out_Valid), 32'd0);
      check("rst_mul_c", 32'(C), 32'd0);
      Rst = 1'b0;
      #1;
      check("rst_mul_in_ready", 32'(In_Ready), 32'd1);
      check("rst_mul_busy", 32'(Busy), 32'd0);
      @(negedge Clk);
      issue(4'b0101, 4'hF, 4'hF);

      // Compare, shift and flag corner cases
      issue(4'b1000, 4'b1001, 4'b1001);
      issue(4'b1000, 4'b1001, 4'b0101);
      issue(4'b0011, 4'b1111, 4'b0111);
      issue(4'b0011, 4'b0111, 4'b1111);
      issue(4'b0110, 4'b1000, 4'b0011);
      issue(4'b1100, 4'b0010, 4'b0001);
      issue(4'b0110, 4'b1011, 4'b1000);
      issue(4'b1100, 4'b1111, 4'b0100);
      issue(4'b0000, 4'b0111, 4'b0001);
      issue(4'b0000, 4'b1111, 4'b0001);
      issue(4'b1111, 4'b0011, 4'b0011);
      issue(4'b1111, 4'b1000, 4'b0001);
      issue(4'b0111, 4'b1010, 4'b0101);
      issue(4'b1001, 4'b1111, 4'b1111);
      issue(4'b0101, 4'b0000, 4'b1111);

      // Randomized traffic with random consumer stalls
      rnd_ready = 1'b1;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            @(negedge Clk);
         end else begin
            issue(4'($urandom), 4'($urandom), 4'($urandom));
         end
      end
      rnd_ready = 1'b0;
      Out_Ready = 1'b1;
      for (int k = 0; k < 200 && exp_q.size() != 0; k++) begin
         @(negedge Clk);
      end
      check("drain_empty", 32'(exp_q.size()), 32'd0);
      repeat (2) @(negedge Clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
